// File: rtl/rgb_frame_reader_if.sv
// Pixel stream bundle between the frame reader and its sink.
// Carries RGB data, pixel address and end-of-frame marker with valid/ready.
interface rgb_frame_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADD_WIDTH  = 12
);
    logic [DATA_WIDTH-1:0] out_R;
    logic [DATA_WIDTH-1:0] out_G;
    logic [DATA_WIDTH-1:0] out_B;
    logic [ADD_WIDTH-1:0]  out_addr;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output out_R, out_G, out_B, out_addr,
        output out_valid, out_last,
        input  out_ready
    );

    modport slave (
        input  out_R, out_G, out_B, out_addr,
        input  out_valid, out_last,
        output out_ready
    );
endinterface

// File: rtl/rgb_frame_reader.sv
// Walks the RGB frame RAM read port and streams pixels with valid/ready.
// A 4-entry FIFO with credit-based issue absorbs sink backpressure.
module rgb_frame_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADD_WIDTH    = 12,
    parameter int FRAME_PIXELS = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADD_WIDTH-1:0]  ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_R,
    input  logic [DATA_WIDTH-1:0] ram_G,
    input  logic [DATA_WIDTH-1:0] ram_B,
    rgb_frame_reader_if.master    pix
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [ADD_WIDTH-1:0] LAST_ADDR =
        ADD_WIDTH'(FRAME_PIXELS - 1);
    localparam int EW = 3 * DATA_WIDTH + ADD_WIDTH + 1;

    state_t state_q, state_d;

    logic [ADD_WIDTH-1:0] addr_q;
    logic                 rd_valid_q;
    logic [ADD_WIDTH-1:0] rd_addr_q;

    logic [EW-1:0] mem [4];
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [2:0]    count;

    logic [EW-1:0]         head;
    logic                  valid;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            count_after_pop;
    logic [DATA_WIDTH-1:0] h_r, h_g, h_b;
    logic [ADD_WIDTH-1:0]  h_addr;
    logic                  h_last;

    assign head  = mem[rd_ptr];
    assign valid = (count != 3'd0);
    assign pop   = valid && pix.out_ready;
    assign push  = rd_valid_q;

    // Credit covers the read whose data lands in the FIFO this edge.
    assign count_after_pop = count - {2'b00, pop};
    assign issue = (state_q == ISSUE) &&
                   ((count_after_pop + {2'b00, rd_valid_q}) < 3'd4);

    // Stale FIFO contents are masked so idle outputs read as zero.
    assign {h_r, h_g, h_b, h_addr, h_last} = valid ? head : '0;

    assign pix.out_R     = h_r;
    assign pix.out_G     = h_g;
    assign pix.out_B     = h_b;
    assign pix.out_addr  = h_addr;
    assign pix.out_last  = h_last;
    assign pix.out_valid = valid;

    assign ram_addr = addr_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   if (issue && addr_q == LAST_ADDR) state_d = DRAIN;
            DRAIN:   if (pop && h_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start)
                addr_q <= '0;
            else if (issue && addr_q != LAST_ADDR)
                addr_q <= addr_q + 1'b1;
            rd_valid_q <= issue;
            rd_addr_q  <= addr_q;
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b00, push} - {2'b00, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {ram_R, ram_G, ram_B, rd_addr_q,
                            rd_addr_q == LAST_ADDR};
    end
endmodule

// File: tb/tb_rgb_frame_reader.sv
// Bench for rgb_frame_reader: frame scenarios table, random backpressure,
// reset abort and small-frame configurations against an expected pixel list.
module tb_rgb_frame_reader;
    localparam int FP = 1024;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    // main instance: 12-bit address, 1024 pixels
    logic        start = 0;
    logic        busy, done;
    logic [11:0] ram_addr;
    logic [7:0]  ram_R, ram_G, ram_B;
    rgb_frame_reader_if #(.DATA_WIDTH(8), .ADD_WIDTH(12)) pix ();

    rgb_frame_reader #(.DATA_WIDTH(8), .ADD_WIDTH(12), .FRAME_PIXELS(FP)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .ram_addr(ram_addr), .ram_R(ram_R), .ram_G(ram_G), .ram_B(ram_B),
        .pix(pix.master)
    );

    // 16-pixel frame with a 4-bit address
    logic       s16_start = 0;
    logic       s16_busy, s16_done;
    logic [3:0] s16_addr;
    logic [7:0] s16_R, s16_G, s16_B;
    rgb_frame_reader_if #(.DATA_WIDTH(8), .ADD_WIDTH(4)) pix16 ();

    rgb_frame_reader #(.DATA_WIDTH(8), .ADD_WIDTH(4), .FRAME_PIXELS(16)) dut16 (
        .clk(clk), .rst(rst), .start(s16_start), .busy(s16_busy),
        .done(s16_done), .ram_addr(s16_addr), .ram_R(s16_R), .ram_G(s16_G),
        .ram_B(s16_B), .pix(pix16.master)
    );

    // single-pixel frame
    logic        s1_start = 0;
    logic        s1_busy, s1_done;
    logic [11:0] s1_addr;
    logic [7:0]  s1_R, s1_G, s1_B;
    rgb_frame_reader_if #(.DATA_WIDTH(8), .ADD_WIDTH(12)) pix1 ();

    rgb_frame_reader #(.DATA_WIDTH(8), .ADD_WIDTH(12), .FRAME_PIXELS(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .busy(s1_busy),
        .done(s1_done), .ram_addr(s1_addr), .ram_R(s1_R), .ram_G(s1_G),
        .ram_B(s1_B), .pix(pix1.master)
    );

    int total = 0;
    int bad   = 0;

    function automatic logic [23:0] pix_of(input int a);
        logic [11:0] x;
        x = a[11:0];
        return {x[7:0], ~x[7:0], x[11:4]};
    endfunction

    // preloaded frame RAMs with one-cycle registered read
    always @(posedge clk) begin
        {ram_R, ram_G, ram_B} <= pix_of(int'(ram_addr));
        {s16_R, s16_G, s16_B} <= pix_of(int'(s16_addr));
        {s1_R, s1_G, s1_B}    <= pix_of(int'(s1_addr));
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_main_reset(input string tag);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_valid"}, 64'(pix.out_valid), 0);
        chk({tag, "_last"}, 64'(pix.out_last), 0);
        chk({tag, "_ram_addr"}, 64'(ram_addr), 0);
        chk({tag, "_rgb"}, 64'({pix.out_R, pix.out_G, pix.out_B}), 0);
        chk({tag, "_out_addr"}, 64'(pix.out_addr), 0);
    endtask

    typedef struct {
        int mode;        // 0 ready=1, 1 random, 2 stall 20 cycles
        int rs_beat;     // start re-pulse at this beat, -1 none
        bit rs_done;     // start pulse in the done cycle
        int rst_beat;    // reset at this beat, -1 none
        int exp_beats;
        int exp_dones;
    } vec_t;

    task automatic run_frame(input vec_t v);
        int beats = 0, dones = 0, done_c = -1, last_c = -1;
        int first_v = -1, c;
        bit prev_stall = 0, rs_sent = 0, aborted = 0;
        logic [36:0] prev, cur;
        logic rdy;

        @(negedge clk);
        start = 1;
        pix.out_ready = 0;
        @(negedge clk);
        start = 0;
        chk("start_busy", 64'(busy), 1);
        chk("start_ram_addr", 64'(ram_addr), 0);
        for (c = 0; c < 8000; c++) begin
            start = 0;
            cur = {pix.out_R, pix.out_G, pix.out_B, pix.out_addr,
                   pix.out_last};
            if (pix.out_valid && first_v < 0) first_v = c;
            if (prev_stall) begin
                chk("stall_valid", 64'(pix.out_valid), 1);
                chk("stall_hold", 64'(cur), 64'(prev));
            end
            if (done) begin
                dones++;
                done_c = c;
                if (v.rs_done) start = 1;
                break;
            end
            if (v.rst_beat >= 0 && beats == v.rst_beat) begin
                rst = 1;
                aborted = 1;
                break;
            end
            if (v.rs_beat >= 0 && beats == v.rs_beat && !rs_sent) begin
                start = 1;
                rs_sent = 1;
            end
            case (v.mode)
                1:       rdy = 1'($urandom_range(0, 1));
                2:       rdy = (c >= 20);
                default: rdy = 1;
            endcase
            if (v.mode == 2 && c == 19)
                chk("stall_ram_addr", 64'(ram_addr), 4);
            pix.out_ready = rdy;
            if (pix.out_valid && rdy) begin
                chk("beat_addr", 64'(pix.out_addr), 64'(beats));
                chk("beat_rgb", 64'({pix.out_R, pix.out_G, pix.out_B}),
                    64'(pix_of(beats)));
                chk("beat_last", 64'(pix.out_last), 64'(beats == FP - 1));
                if (beats == FP - 1) last_c = c;
                beats++;
            end
            prev_stall = pix.out_valid && !rdy;
            prev = cur;
            @(negedge clk);
        end
        chk("beat_count", 64'(beats), 64'(v.exp_beats));
        chk("first_valid_cycle", 64'(first_v), 2);
        @(negedge clk);
        start = 0;
        if (aborted) begin
            chk_main_reset("rst_mid");
            rst = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (done) dones++;
            end
        end else begin
            chk("done_after_last", 64'(done_c), 64'(last_c + 1));
            if (v.mode == 0)
                chk("last_beat_cycle", 64'(last_c), 64'(FP + 1));
            chk("done_one_pulse", 64'(done), 0);
            chk("busy_fall", 64'(busy), 0);
        end
        chk("done_count", 64'(dones), 64'(v.exp_dones));
    endtask

    vec_t vecs[6];

    initial begin
        int b16 = 0, b1 = 0, d16 = 0, d1 = 0;
        vecs[0] = '{0, -1, 0, -1, FP, 1};
        vecs[1] = '{1, -1, 0, -1, FP, 1};
        vecs[2] = '{2, -1, 0, -1, FP, 1};
        vecs[3] = '{0, 300, 1, -1, FP, 1};
        vecs[4] = '{0, -1, 0, 500, 500, 0};
        vecs[5] = '{0, -1, 0, -1, FP, 1};

        pix.out_ready   = 0;
        pix16.out_ready = 1;
        pix1.out_ready  = 1;
        repeat (3) @(negedge clk);
        chk_main_reset("reset");
        chk("reset_s16_valid", 64'(pix16.out_valid), 0);
        chk("reset_s1_valid", 64'(pix1.out_valid), 0);
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        @(negedge clk);
        s16_start = 1;
        s1_start  = 1;
        @(negedge clk);
        s16_start = 0;
        s1_start  = 0;
        for (int c = 0; c < 40; c++) begin
            if (pix16.out_valid) begin
                chk("s16_addr", 64'(pix16.out_addr), 64'(b16));
                chk("s16_rgb", 64'({pix16.out_R, pix16.out_G, pix16.out_B}),
                    64'(pix_of(b16)));
                chk("s16_last", 64'(pix16.out_last), 64'(b16 == 15));
                b16++;
            end
            if (pix1.out_valid) begin
                chk("s1_addr", 64'(pix1.out_addr), 0);
                chk("s1_last", 64'(pix1.out_last), 1);
                b1++;
            end
            if (s16_done) d16++;
            if (s1_done) d1++;
            @(negedge clk);
        end
        chk("s16_beats", 64'(b16), 16);
        chk("s16_dones", 64'(d16), 1);
        chk("s16_ram_addr_nowrap", 64'(s16_addr), 15);
        chk("s1_beats", 64'(b1), 1);
        chk("s1_dones", 64'(d1), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
